mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory pipeline stage: single-outstanding data-bus master with lane steering,
// load extraction and a bubble-inserting stall. Optional macro MEM_ALIGN_CHECK_EN.
module mem_stage (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MEM_RegWrite,
    input  logic        MEM_MemToReg,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_MemSize,
    input  logic        MEM_LoadUnsigned,
    input  logic [31:0] MEM_ALUOut,
    input  logic [31:0] MEM_WriteToMemData,
    input  logic [4:0]  MEM_WriteRegAddr,
    output logic        Stall,
    output logic        DMem_Req,
    output logic        DMem_We,
    output logic [31:0] DMem_Addr,
    output logic [3:0]  DMem_BE,
    output logic [31:0] DMem_WData,
    input  logic        DMem_Ack,
    input  logic [31:0] DMem_RData,
    output logic        WB_RegWrite,
    output logic [4:0]  WB_WriteRegAddr,
    output logic [31:0] WB_WriteData,
    output logic        Exc_AdE
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_next;
    logic        mem_op, is_store, misaligned;
    logic [1:0]  lane;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] load_data;

    // Load context captured at request time; upstream may advance on the Ack edge.
    logic [1:0]  ld_size, ld_lane;
    logic        ld_unsigned, ld_regwrite;
    logic [4:0]  ld_rd;

    assign mem_op   = MEM_MemToReg | MEM_MemWrite;
    assign is_store = MEM_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op &&
                        ((MEM_MemSize == 2'b01 && MEM_ALUOut[0]) ||
                         (MEM_MemSize[1] && MEM_ALUOut[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
    assign Exc_AdE    = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        lane       = 2'b00;
        be_calc    = 4'b1111;
        wdata_calc = MEM_WriteToMemData;
        case (MEM_MemSize)
            2'b00: begin
                lane       = MEM_ALUOut[1:0];
                be_calc    = 4'b0001 << MEM_ALUOut[1:0];
                wdata_calc = {4{MEM_WriteToMemData[7:0]}};
            end
            2'b01: begin
                lane       = {MEM_ALUOut[1], 1'b0};
                be_calc    = MEM_ALUOut[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{MEM_WriteToMemData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b         = DMem_RData[{ld_lane, 3'b000} +: 8];
        h         = ld_lane[1] ? DMem_RData[31:16] : DMem_RData[15:0];
        load_data = DMem_RData;
        case (ld_size)
            2'b00:   load_data = {{24{~ld_unsigned & b[7]}}, b};
            2'b01:   load_data = {{16{~ld_unsigned & h[15]}}, h};
            default: ;
        endcase
    end

    // Stall is forced low while reset is asserted.
    always_comb begin
        state_next = state;
        Stall      = 1'b0;
        if (Rst) begin
            unique case (state)
                IDLE: if (mem_op && !misaligned) begin
                    Stall      = 1'b1;
                    state_next = WAIT;
                end
                WAIT: if (DMem_Ack) state_next = IDLE;
                      else          Stall      = 1'b1;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state           <= IDLE;
            DMem_Req        <= 1'b0;
            DMem_We         <= 1'b0;
            DMem_Addr       <= '0;
            DMem_BE         <= '0;
            DMem_WData      <= '0;
            WB_RegWrite     <= 1'b0;
            WB_WriteRegAddr <= '0;
            WB_WriteData    <= '0;
            ld_size         <= '0;
            ld_lane         <= '0;
            ld_unsigned     <= 1'b0;
            ld_regwrite     <= 1'b0;
            ld_rd           <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            Exc_AdE         <= 1'b0;
`endif
        end else begin
            state <= state_next;
`ifdef MEM_ALIGN_CHECK_EN
            Exc_AdE <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (mem_op && !misaligned) begin
                        DMem_Req    <= 1'b1;
                        DMem_We     <= is_store;
                        DMem_Addr   <= {MEM_ALUOut[31:2], 2'b00};
                        DMem_BE     <= be_calc;
                        DMem_WData  <= wdata_calc;
                        WB_RegWrite <= 1'b0;
                        ld_size     <= MEM_MemSize;
                        ld_lane     <= lane;
                        ld_unsigned <= MEM_LoadUnsigned;
                        ld_regwrite <= MEM_RegWrite & ~is_store;
                        ld_rd       <= MEM_WriteRegAddr;
                    end else if (misaligned) begin
                        WB_RegWrite <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                        Exc_AdE     <= 1'b1;
`endif
                    end else begin
                        WB_RegWrite     <= MEM_RegWrite;
                        WB_WriteRegAddr <= MEM_WriteRegAddr;
                        WB_WriteData    <= MEM_ALUOut;
                    end
                end
                WAIT: begin
                    if (DMem_Ack) begin
                        DMem_Req        <= 1'b0;
                        WB_RegWrite     <= ld_regwrite;
                        WB_WriteRegAddr <= ld_rd;
                        WB_WriteData    <= load_data;
                    end else begin
                        WB_RegWrite <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes expected bus requests and WB writes
// from a byte-lane reference model; an independent monitor pops and compares them.
module tb_mem_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        MEM_RegWrite, MEM_MemToReg, MEM_MemWrite, MEM_LoadUnsigned;
    logic [1:0]  MEM_MemSize;
    logic [31:0] MEM_ALUOut, MEM_WriteToMemData;
    logic [4:0]  MEM_WriteRegAddr;
    logic        Stall, DMem_Req, DMem_We, DMem_Ack;
    logic [31:0] DMem_Addr, DMem_WData, DMem_RData;
    logic [3:0]  DMem_BE;
    logic        WB_RegWrite, Exc_AdE;
    logic [4:0]  WB_WriteRegAddr;
    logic [31:0] WB_WriteData;

    mem_stage dut (
        .Clk(Clk), .Rst(Rst),
        .MEM_RegWrite(MEM_RegWrite), .MEM_MemToReg(MEM_MemToReg), .MEM_MemWrite(MEM_MemWrite),
        .MEM_MemSize(MEM_MemSize), .MEM_LoadUnsigned(MEM_LoadUnsigned), .MEM_ALUOut(MEM_ALUOut),
        .MEM_WriteToMemData(MEM_WriteToMemData), .MEM_WriteRegAddr(MEM_WriteRegAddr),
        .Stall(Stall), .DMem_Req(DMem_Req), .DMem_We(DMem_We), .DMem_Addr(DMem_Addr),
        .DMem_BE(DMem_BE), .DMem_WData(DMem_WData), .DMem_Ack(DMem_Ack), .DMem_RData(DMem_RData),
        .WB_RegWrite(WB_RegWrite), .WB_WriteRegAddr(WB_WriteRegAddr), .WB_WriteData(WB_WriteData),
        .Exc_AdE(Exc_AdE)
    );

    always #5 Clk = ~Clk;

    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;

    bus_t        bus_q[$];
    wb_t         wb_q[$];
    int          exc_pending = 0;
    int          n_tests = 0, n_fail = 0;
    bit          use_fixed = 0;
    logic [31:0] fixed_rdata = '0;
    bit          seen_req;
    logic        seen_we;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_be;
    int          last_stalls;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte counts and lane offsets in plain arithmetic.
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic int lane_of(input logic [1:0] size, input logic [31:0] a);
        return ((a % 4) / nbytes(size)) * nbytes(size);
    endfunction

    function automatic bit is_misaligned(input logic [1:0] size, input logic [31:0] a);
        bit m = (a % nbytes(size)) != 0;
`ifndef MEM_ALIGN_CHECK_EN
        m = 1'b0;
`endif
        return m;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    function automatic logic [31:0] byte_mask(input int n);
        return (n == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * n)) - 1);
    endfunction

    function automatic bus_t exp_bus(input logic we, input logic [1:0] size,
                                     input logic [31:0] a, input logic [31:0] d);
        bus_t e;
        int   n = nbytes(size);
        e.we    = we;
        e.addr  = a - (a % 4);
        e.be    = 4'(((1 << n) - 1) << lane_of(size, a));
        e.wdata = '0;
        for (int i = 0; i < 4 / n; i++) e.wdata |= (d & byte_mask(n)) << (8 * n * i);
        return e;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] a, input logic [31:0] word);
        int          n    = nbytes(size);
        logic [31:0] mask = byte_mask(n);
        logic [31:0] v    = (word >> (8 * lane_of(size, a))) & mask;
        if (n < 4 && !uns && v[8 * n - 1]) v |= ~mask;
        return v;
    endfunction

    always_comb DMem_RData = use_fixed ? fixed_rdata : mem_word(DMem_Addr);

    task automatic drive_nop();
        MEM_RegWrite = 0; MEM_MemToReg = 0; MEM_MemWrite = 0; MEM_MemSize = 2'b10;
        MEM_LoadUnsigned = 0; MEM_ALUOut = '0; MEM_WriteToMemData = '0; MEM_WriteRegAddr = '0;
        DMem_Ack = 0;
    endtask

    // Present one instruction, hold it while stalled, emulate the bus slave.
    task automatic issue(input logic rw, input logic mtr, input logic mw, input logic [1:0] size,
                         input logic uns, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] rd, input int delay, input bit spurious);
        bit          mem = mtr | mw;
        bit          mis = mem && is_misaligned(size, alu);
        int          wait_left = -1, used_delay = 0, stalls = 0;
        logic        exp_stall;
        logic [31:0] word = use_fixed ? fixed_rdata : mem_word(alu - (alu % 4));
        seen_req = 0;
        if (!mem) begin
            if (rw) wb_q.push_back(wb_t'{rd, alu});
        end else if (mis) begin
            exc_pending++;
        end else begin
            bus_q.push_back(exp_bus(mw, size, alu, wd));
            if (!mw && rw) wb_q.push_back(wb_t'{rd, exp_load(size, uns, alu, word)});
        end
        forever begin
            @(negedge Clk);
            MEM_RegWrite = rw; MEM_MemToReg = mtr; MEM_MemWrite = mw; MEM_MemSize = size;
            MEM_LoadUnsigned = uns; MEM_ALUOut = alu; MEM_WriteToMemData = wd; MEM_WriteRegAddr = rd;
            if (DMem_Req) begin
                if (!seen_req) begin
                    seen_req = 1; seen_we = DMem_We; seen_addr = DMem_Addr;
                    seen_be = DMem_BE; seen_wdata = DMem_WData;
                end
                if (wait_left < 0) begin
                    wait_left  = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
                    used_delay = wait_left;
                end
                DMem_Ack = (wait_left == 0);
                wait_left--;
            end else begin
                DMem_Ack = spurious && ($urandom_range(0, 3) == 0);
            end
            #1;
            exp_stall = (mem && !mis) ? (DMem_Req ? !DMem_Ack : 1'b1) : 1'b0;
            check("stall", Stall, exp_stall);
            if (!Stall) break;
            stalls++;
            if (stalls > 40) begin
                check("stall_timeout", stalls, 0);
                break;
            end
        end
        @(posedge Clk);
        #1;
        drive_nop();
        last_stalls = stalls;
        check("stall_cycles", stalls, (mem && !mis) ? 1 + used_delay : 0);
    endtask

    // Monitor: compares every DUT-presented bus request and WB write with the queues.
    initial begin
        logic prev_req = 1'b0;
        bus_t held, e;
        wb_t  w;
        forever begin
            @(negedge Clk);
            if (DMem_Req && !prev_req) begin
                held = bus_t'{DMem_We, DMem_Addr, DMem_BE, DMem_WData};
                if (bus_q.size() == 0) check("req_unexpected", DMem_Req, 0);
                else begin
                    e = bus_q.pop_front();
                    check("bus_we", DMem_We, e.we);
                    check("bus_addr", DMem_Addr, e.addr);
                    check("bus_be", DMem_BE, e.be);
                    check("bus_wdata", DMem_WData, e.wdata);
                end
            end else if (DMem_Req) begin
                check("bus_hold_addr", DMem_Addr, held.addr);
                check("bus_hold_be", DMem_BE, held.be);
                check("bus_hold_wdata", DMem_WData, held.wdata);
                check("bus_hold_we", DMem_We, held.we);
            end
            if (WB_RegWrite) begin
                if (wb_q.size() == 0) check("wb_unexpected", WB_RegWrite, 0);
                else begin
                    w = wb_q.pop_front();
                    check("wb_rd", WB_WriteRegAddr, w.rd);
                    check("wb_data", WB_WriteData, w.data);
                end
            end
            if (Exc_AdE) begin
                if (exc_pending > 0) exc_pending--;
                else check("exc_unexpected", Exc_AdE, 0);
            end
            prev_req = DMem_Req;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 0;
        drive_nop();
        MEM_MemToReg = 1; MEM_RegWrite = 1; DMem_Ack = 1;
        repeat (2) begin
            @(negedge Clk); #1;
            check("rst_stall", Stall, 0);
        end
        check("rst_req", DMem_Req, 0);
        check("rst_we", DMem_We, 0);
        check("rst_addr", DMem_Addr, 0);
        check("rst_be", DMem_BE, 0);
        check("rst_wdata", DMem_WData, 0);
        check("rst_wb_we", WB_RegWrite, 0);
        check("rst_wb_rd", WB_WriteRegAddr, 0);
        check("rst_wb_data", WB_WriteData, 0);
        check("rst_exc", Exc_AdE, 0);
        drive_nop();
        Rst = 1;

        // ADD result 5 to $3
        issue(1, 0, 0, 2'b10, 0, 32'h5, 32'h0, 5'd3, 0, 0);
        @(negedge Clk);
        check("add_we", WB_RegWrite, 1);
        check("add_rd", WB_WriteRegAddr, 3);
        check("add_data", WB_WriteData, 32'h5);

        // LB signed from 0x1003, read word 0x80FFFFFF, immediate Ack
        use_fixed = 1; fixed_rdata = 32'h80FFFFFF;
        issue(1, 1, 0, 2'b00, 0, 32'h1003, 32'h0, 5'd7, 0, 0);
        check("lb_be", seen_be, 4'b1000);
        check("lb_stalls", last_stalls, 1);
        @(negedge Clk);
        check("lb_data", WB_WriteData, 32'hFFFFFF80);
        use_fixed = 0;

        // SH to 0x2002, Ack after three WAIT cycles
        issue(0, 0, 1, 2'b01, 0, 32'h2002, 32'h0000ABCD, 5'd9, 3, 0);
        check("sh_we", seen_we, 1);
        check("sh_be", seen_be, 4'b1100);
        check("sh_wdata", seen_wdata, 32'hABCDABCD);
        check("sh_stalls", last_stalls, 4);

        // LW from 0x3001
        issue(1, 1, 0, 2'b10, 0, 32'h3001, 32'h0, 5'd4, 0, 0);
`ifdef MEM_ALIGN_CHECK_EN
        check("lw_mis_req", seen_req, 0);
        @(negedge Clk);
        check("lw_mis_exc", Exc_AdE, 1);
        check("lw_mis_wb", WB_RegWrite, 0);
`else
        check("lw_addr", seen_addr, 32'h3000);
        check("lw_be", seen_be, 4'b1111);
`endif

        // Reset during WAIT, then a spurious Ack
        bus_q.push_back(exp_bus(0, 2'b10, 32'h4000, 32'h0));
        @(negedge Clk);
        MEM_MemToReg = 1; MEM_RegWrite = 1; MEM_ALUOut = 32'h4000; MEM_WriteRegAddr = 5'd5;
        #1 check("wait_rst_stall0", Stall, 1);
        @(negedge Clk);
        check("wait_rst_req_before", DMem_Req, 1);
        Rst = 0;
        #1 check("wait_rst_stall1", Stall, 0);
        @(negedge Clk);
        check("wait_rst_req", DMem_Req, 0);
        check("wait_rst_be", DMem_BE, 0);
        check("wait_rst_addr", DMem_Addr, 0);
        check("wait_rst_wb", WB_RegWrite, 0);
        check("wait_rst_wbdata", WB_WriteData, 0);
        drive_nop();
        Rst = 1; DMem_Ack = 1;
        #1 check("spur_stall", Stall, 0);
        @(negedge Clk);
        check("spur_req", DMem_Req, 0);
        check("spur_wb", WB_RegWrite, 0);
        DMem_Ack = 0;

        // Randomized back-to-back traffic with random Ack latency and spurious Acks
        for (int i = 0; i < 400; i++) begin
            int          kind = $urandom_range(0, 3);
            logic        mtr  = (kind == 1) || (kind == 3);
            logic        mw   = (kind == 2) || (kind == 3);
            issue(logic'($urandom_range(0, 3) != 0), mtr, mw, 2'($urandom_range(0, 3)),
                  logic'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                  -1, 1);
        end

        repeat (3) @(negedge Clk);
        check("bus_q_drained", bus_q.size(), 0);
        check("wb_q_drained", wb_q.size(), 0);
        check("exc_drained", exc_pending, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
